// File: rtl/rx_deser_if.sv
// rtl/rx_deser_if.sv - byte input strobe and block output valid/ready bundle for rx_deser
interface rx_deser_if #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 16
);
    logic [BYTE_W-1:0]           in_data;
    logic                        in_valid;
    logic [BYTE_W*NUM_BYTES-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/rx_deser.sv
// rtl/rx_deser.sv - double-buffered byte-to-block deserializer with timeout and overrun
module rx_deser #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    rx_deser_if.slave                      bus,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
    output logic                           overrun,
    output logic                           timeout_err
);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int ACC_W = (NUM_BYTES - 1) * BYTE_W;
    localparam int BLK_W = NUM_BYTES * BYTE_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BYTES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BYTE_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [BLK_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;
    logic               timeout_err_q, timeout_err_d;
    logic               hs;

    // The accumulator is kept in arrival order; byte order is applied only here.
    function automatic logic [BLK_W-1:0] assemble(input logic [ACC_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] last);
        logic [BLK_W-1:0] arrival;
        logic [BLK_W-1:0] blk;
        arrival = {last, acc};
        blk     = arrival;
        if (MSB_FIRST) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                blk[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W] = arrival[i*BYTE_W +: BYTE_W];
            end
        end
        return blk;
    endfunction

    assign hs = out_valid_q & bus.out_ready;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        hold_d        = hold_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q & ~hs;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;

        if (state_q == COLLECT) begin
            if (clear) begin
                cnt_d   = '0;
                timer_d = '0;
            end else if (bus.in_valid) begin
                timer_d = '0;
                if (cnt_q == LAST_IDX) begin
                    if (!out_valid_q || hs) begin
                        out_data_d  = assemble(acc_q, bus.in_data);
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        hold_d  = bus.in_data;
                        state_d = FULL;
                        cnt_d   = FULL_CNT;
                    end
                end else begin
                    for (int i = 0; i < NUM_BYTES - 1; i++) begin
                        if (cnt_q == CNT_W'(i)) acc_d[i*BYTE_W +: BYTE_W] = bus.in_data;
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (TIMEOUT > 0 && cnt_q != '0) begin
                // A strobe in the expiry cycle takes the branch above, so it always wins.
                if (timer_q >= TMR_LAST) begin
                    cnt_d         = '0;
                    acc_d         = '0;
                    timer_d       = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end else begin
            if (clear) begin
                state_d = COLLECT;
                cnt_d   = '0;
                timer_d = '0;
            end else if (hs) begin
                out_data_d  = assemble(acc_q, hold_q);
                out_valid_d = 1'b1;
                state_d     = COLLECT;
                timer_d     = '0;
                if (bus.in_valid) begin
                    acc_d[BYTE_W-1:0] = bus.in_data;
                    cnt_d             = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end else if (bus.in_valid) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= COLLECT;
            acc_q         <= '0;
            hold_q        <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign byte_cnt      = cnt_q;
    assign overrun       = overrun_q;
    assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_rx_deser.sv
// tb/tb_rx_deser.sv - random and directed checks of rx_deser against a queue-level model
module tb_rx_deser;
    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic [4:0] cnt_a, cnt_b;
    logic       ovr_a, ovr_b, to_a, to_b;

    rx_deser_if #(.BYTE_W(8), .NUM_BYTES(16)) bus_a ();
    rx_deser_if #(.BYTE_W(8), .NUM_BYTES(16)) bus_b ();

    assign bus_a.in_data   = in_data;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_data   = in_data;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.out_ready = out_ready;

    rx_deser #(.BYTE_W(8), .NUM_BYTES(16), .MSB_FIRST(1'b1), .TIMEOUT(100)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus_a.slave),
        .byte_cnt(cnt_a), .overrun(ovr_a), .timeout_err(to_a)
    );
    rx_deser #(.BYTE_W(8), .NUM_BYTES(16), .MSB_FIRST(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus_b.slave),
        .byte_cnt(cnt_b), .overrun(ovr_b), .timeout_err(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: instance 0 = MSB-first with 100-cycle timeout, instance 1 = LSB-first, no timeout.
    logic [7:0]   part [2][16];
    int           pcnt [2];
    int           midle [2];
    bit           mfull [2];
    logic [127:0] mheld [2];
    logic [127:0] mout [2];
    bit           mval [2];
    bit           movr [2];
    bit           mto [2];

    function automatic int to_of(input int k);
        return (k == 0) ? 100 : 0;
    endfunction

    function automatic logic [127:0] pack(input int k);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (k == 0) r[(15-i)*8 +: 8] = part[k][i];
            else        r[i*8 +: 8]      = part[k][i];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pcnt[k] = 0; midle[k] = 0; mfull[k] = 0; mheld[k] = '0;
            mout[k] = '0; mval[k] = 0; movr[k] = 0; mto[k] = 0;
        end
    endtask

    task automatic model_step();
        bit hs, free;
        for (int k = 0; k < 2; k++) begin
            hs   = mval[k] && out_ready;
            free = !mval[k] || hs;
            movr[k] = 0;
            mto[k]  = 0;
            if (hs) mval[k] = 0;
            if (mfull[k]) begin
                if (clear) begin
                    mfull[k] = 0; pcnt[k] = 0; midle[k] = 0;
                end else if (hs) begin
                    mout[k] = mheld[k]; mval[k] = 1; mfull[k] = 0; pcnt[k] = 0; midle[k] = 0;
                    if (in_valid) begin
                        part[k][0] = in_data; pcnt[k] = 1;
                    end
                end else if (in_valid) begin
                    movr[k] = 1;
                end
            end else if (clear) begin
                pcnt[k] = 0; midle[k] = 0;
            end else if (in_valid) begin
                part[k][pcnt[k]] = in_data;
                pcnt[k]++;
                midle[k] = 0;
                if (pcnt[k] == 16) begin
                    if (free) begin
                        mout[k] = pack(k); mval[k] = 1; pcnt[k] = 0;
                    end else begin
                        mheld[k] = pack(k); mfull[k] = 1;
                    end
                end
            end else if (to_of(k) > 0 && pcnt[k] > 0) begin
                midle[k]++;
                if (midle[k] == to_of(k)) begin
                    pcnt[k] = 0; midle[k] = 0; mto[k] = 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (checking) begin
                chk("a_data",  bus_a.out_data,  mout[0]);
                chk("a_valid", bus_a.out_valid, mval[0]);
                chk("a_cnt",   cnt_a,           pcnt[0]);
                chk("a_ovr",   ovr_a,           movr[0]);
                chk("a_to",    to_a,            mto[0]);
                chk("b_data",  bus_b.out_data,  mout[1]);
                chk("b_valid", bus_b.out_valid, mval[1]);
                chk("b_cnt",   cnt_b,           pcnt[1]);
                chk("b_ovr",   ovr_b,           movr[1]);
                chk("b_to",    to_b,            mto[1]);
            end
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
    endtask

    int n;

    initial begin
        reset = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        #3 reset = 1'b0;
        #1;
        chk("rst_data",  bus_a.out_data,  128'h0);
        chk("rst_valid", bus_a.out_valid, 1'b0);
        chk("rst_cnt",   cnt_a,           5'd0);
        chk("rst_ovr",   ovr_a,           1'b0);
        chk("rst_to",    to_a,            1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checking = 1'b1;

        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 1, 0);
        cyc(0, 0, 1, 0);
        #1;
        chk("msb_block", bus_a.out_data, 128'h000102030405060708090a0b0c0d0e0f);
        chk("lsb_block", bus_b.out_data, 128'h0f0e0d0c0b0a09080706050403020100);
        chk("blk_valid", bus_a.out_valid, 1'b1);
        chk("blk_cnt",   cnt_a,           5'd0);

        for (int i = 0; i < 32; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'h55, 0, 0);
        cyc(0, 0, 0, 0);
        #1;
        chk("full_data", bus_a.out_data, 128'h000102030405060708090a0b0c0d0e0f);
        chk("full_cnt",  cnt_a,          5'd16);
        chk("full_ovr",  ovr_a,          1'b1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        #1;
        chk("held_data",  bus_a.out_data,  128'h101112131415161718191a1b1c1d1e1f);
        chk("held_valid", bus_a.out_valid, 1'b1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 1, 0);
        n = 0;
        repeat (102) begin
            cyc(0, 0, 1, 0);
            #1;
            if (to_a) n++;
        end
        chk("to_pulses", n, 1);
        chk("to_cnt",    cnt_a, 5'd0);
        chk("noto_cnt",  cnt_b, 5'd5);
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'ha0 + i), 1, 0);
        cyc(0, 0, 1, 0);
        #1;
        chk("to_block", bus_a.out_data, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 1, 0);
        n = 0;
        repeat (99) begin
            cyc(0, 0, 1, 0);
            #1;
            if (to_a) n++;
        end
        cyc(1, 8'h77, 1, 0);
        cyc(0, 0, 1, 0);
        #1;
        if (to_a) n++;
        chk("edge_cnt",    cnt_a, 5'd6);
        chk("edge_no_to",  n,     0);
        for (int i = 0; i < 10; i++) cyc(1, 8'(i), 1, 0);
        cyc(0, 0, 1, 0);

        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 15; i++) cyc(1, 8'(8'h30 + i), 0, 0);
        cyc(1, 8'h3f, 1, 0);
        cyc(0, 0, 0, 0);
        #1;
        chk("hs_valid", bus_a.out_valid, 1'b1);
        chk("hs_data",  bus_a.out_data,  128'h303132333435363738393a3b3c3d3e3f);

        for (int i = 0; i < 7; i++) cyc(1, 8'(i), 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_data",  bus_a.out_data,  128'h0);
        chk("mid_rst_valid", bus_a.out_valid, 1'b0);
        chk("mid_rst_cnt",   cnt_a,           5'd0);
        chk("mid_rst_cnt_b", cnt_b,           5'd0);
        cyc(0, 0, 1, 0);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 1, 0);
        cyc(0, 0, 1, 0);
        #1;
        chk("post_rst_a", bus_a.out_data, 128'h404142434445464748494a4b4c4d4e4f);
        chk("post_rst_b", bus_b.out_data, 128'h4f4e4d4c4b4a49484746454443424140);

        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 299) == 0) begin
                repeat (110) cyc(0, 0, 1, 0);
            end
            cyc($urandom_range(0, 99) < 65, 8'($urandom), (it / 64) % 3 != 1 && $urandom_range(0, 3) != 0,
                $urandom_range(0, 59) == 0);
        end
        cyc(0, 0, 1, 0);
        repeat (3) @(negedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
